// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_BYTES    = 32'd4;
    localparam logic [31:0] PC_READ_OFFSET = 32'd8;
    localparam logic [31:0] ARM_NOP        = 32'hE1A0_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - ROM, redirect and decode handshake bundle of the fetch stage
interface fetch_unit_if;

    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus8;

    modport master (
        output imem_a,
        input  imem_rd,
        input  branch_valid,
        input  branch_target,
        output if_valid,
        input  id_ready,
        output if_instr,
        output if_pc,
        output if_pc_plus8
    );

    modport slave (
        input  imem_a,
        output imem_rd,
        output branch_valid,
        output branch_target,
        input  if_valid,
        output id_ready,
        input  if_instr,
        input  if_pc,
        input  if_pc_plus8
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - skid FIFO of fetched {pc, instr} entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // a full FIFO may still accept a push when the head leaves in the same cycle
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, ROM addressing and decode handoff of the ARM fetch stage
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_WORD = ARM_NOP
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    logic [31:0]            pc;
    logic                   push;
    logic                   pop;
    fetch_entry_t           din;
    fetch_entry_t           head;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;

    assign pop  = bus.if_valid & bus.id_ready;
    // a redirect suppresses the push so the word fetched from the old path is dropped
    assign push = ~bus.branch_valid & (~full | pop);
    assign din  = '{pc: pc, instr: bus.imem_rd};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= {RESET_PC[31:2], 2'b00};
        else if (bus.branch_valid)
            pc <= {bus.branch_target[31:2], 2'b00};
        else if (push)
            pc <= pc + INSTR_BYTES;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.branch_valid),
        .din   (din),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.imem_a      = pc;
    assign bus.if_valid    = |count;
    assign bus.if_instr    = empty ? NOP_WORD : head.instr;
    assign bus.if_pc       = empty ? 32'h0 : head.pc;
    assign bus.if_pc_plus8 = bus.if_pc + PC_READ_OFFSET;

endmodule
